// File: rtl/dmem_dma_pkg.sv
// Shared types and constants for the data-memory DMA engine and its address generator.
package dmem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic MODE_RD = 1'b0;
  localparam logic MODE_WR = 1'b1;

  localparam int unsigned WORD_BYTES = 4;

  // A word is reachable only if its last byte still falls inside the memory; 33 bits avoid wrap.
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned mem_bytes);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'(WORD_BYTES - 1);
    return last_byte <= (33'(mem_bytes) - 33'd1);
  endfunction

endpackage

// File: rtl/dmem_dma_engine_if.sv
// Control, memory-port and stream signals of the DMA engine; master is the engine side.
interface dmem_dma_engine_if
  import dmem_dma_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic             start;
  logic             mode;
  logic [31:0]      base_addr;
  logic [31:0]      stride;
  logic [CNT_W-1:0] word_count;
  logic             busy;
  logic             done;
  logic             err;

  logic [31:0]      ADDR;
  logic [31:0]      WriteData;
  logic             MemWrite;
  logic [31:0]      ReadData;

  logic             m_valid;
  logic [31:0]      m_data;
  logic             m_ready;

  logic             s_valid;
  logic [31:0]      s_data;
  logic             s_ready;

  modport master (
    input  start, mode, base_addr, stride, word_count,
    input  ReadData, m_ready, s_valid, s_data,
    output busy, done, err,
    output ADDR, WriteData, MemWrite,
    output m_valid, m_data, s_ready
  );

  modport slave (
    output start, mode, base_addr, stride, word_count,
    output ReadData, m_ready, s_valid, s_data,
    input  busy, done, err,
    input  ADDR, WriteData, MemWrite,
    input  m_valid, m_data, s_ready
  );

endinterface

// File: rtl/dmem_dma_engine_addr_gen.sv
// Current-address and remaining-word counters with the per-access range check.
module dmem_addr_gen
  import dmem_dma_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1017,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic [31:0]      base_i,
  input  logic [31:0]      stride_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             advance_i,
  output logic [31:0]      cur_addr_o,
  output logic             rem_zero_o,
  output logic             range_ok_o
);

  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [31:0]      stride_q, stride_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // A new start reloads everything; otherwise each accepted word steps the address (mod 2^32).
  always_comb begin
    cur_addr_d = cur_addr_q;
    stride_d   = stride_q;
    rem_d      = rem_q;
    if (init_i) begin
      cur_addr_d = base_i;
      stride_d   = stride_i;
      rem_d      = count_i;
    end else if (advance_i) begin
      cur_addr_d = cur_addr_q + stride_q;
      rem_d      = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q <= '0;
      stride_q   <= '0;
      rem_q      <= '0;
    end else begin
      cur_addr_q <= cur_addr_d;
      stride_q   <= stride_d;
      rem_q      <= rem_d;
    end
  end

  assign cur_addr_o = cur_addr_q;
  assign rem_zero_o = (rem_q == '0);
  assign range_ok_o = word_in_range(cur_addr_q, MEM_BYTES);

endmodule

// File: rtl/dmem_dma_engine.sv
// Block-transfer initiator: streams memory words out (read) or drains a stream into memory (write).
module dmem_dma_engine
  import dmem_dma_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1017,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  dmem_dma_engine_if.master bus
);

  state_e      state_q;
  logic        mode_q;
  logic        err_q;
  logic        m_valid_q;
  logic [31:0] m_data_q;
  logic [31:0] addr_hold_q;

  logic        start_acc;
  logic        in_run;
  logic        rem_zero;
  logic        range_ok;
  logic [31:0] cur_addr;
  logic        range_err;
  logic        load;
  logic        s_ready;
  logic        wr_fire;
  logic        drained;

  assign start_acc = (state_q == IDLE) && bus.start;
  assign in_run    = (state_q == RUN);

  dmem_addr_gen #(
    .MEM_BYTES (MEM_BYTES),
    .CNT_W     (CNT_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .init_i     (start_acc),
    .base_i     (bus.base_addr),
    .stride_i   (bus.stride),
    .count_i    (bus.word_count),
    .advance_i  (load || wr_fire),
    .cur_addr_o (cur_addr),
    .rem_zero_o (rem_zero),
    .range_ok_o (range_ok)
  );

  // An out-of-range word aborts the transfer before any memory access is attempted.
  assign range_err = in_run && !rem_zero && !range_ok;
  assign load      = in_run && (mode_q == MODE_RD) && !rem_zero && range_ok &&
                     (!m_valid_q || bus.m_ready);
  assign s_ready   = in_run && (mode_q == MODE_WR) && !rem_zero && range_ok;
  assign wr_fire   = s_ready && bus.s_valid;
  assign drained   = !m_valid_q || bus.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_RD;
      err_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      addr_hold_q <= '0;
    end else begin
      if (in_run) begin
        addr_hold_q <= cur_addr;
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            mode_q  <= bus.mode;
            err_q   <= 1'b0;
          end
        end
        RUN: begin
          if (range_err) begin
            err_q     <= 1'b1;
            m_valid_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            if (load) begin
              m_data_q  <= bus.ReadData;
              m_valid_q <= 1'b1;
            end else if (m_valid_q && bus.m_ready) begin
              m_valid_q <= 1'b0;
            end
            // Read mode waits for the last word to leave the output register before finishing.
            if (rem_zero && drained) begin
              m_valid_q <= 1'b0;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign bus.ADDR      = in_run ? cur_addr : addr_hold_q;
  assign bus.MemWrite  = wr_fire;
  assign bus.WriteData = wr_fire ? bus.s_data : 32'h0;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.s_ready   = s_ready;

endmodule

// File: tb/tb_dmem_dma_engine.sv
// Directed-vector bench for dmem_dma_engine with a byte memory model and queue scoreboards.
module tb_dmem_dma_engine;
  import dmem_dma_pkg::*;

  localparam int unsigned MEM_BYTES = 1017;
  localparam int unsigned CNT_W     = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   doneCnt;
  int   memWrCnt;

  logic [7:0]  mem [0:1023];
  logic [31:0] rdQ[$];
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  dmem_dma_engine_if #(.CNT_W(CNT_W)) bus ();

  dmem_dma_engine #(
    .MEM_BYTES (MEM_BYTES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read; out-of-range addresses read back as zero.
  logic [9:0] rdIdx;
  always_comb begin
    rdIdx        = bus.ADDR[9:0];
    bus.ReadData = 32'h0;
    if (({1'b0, bus.ADDR} + 33'd3) < 33'(MEM_BYTES)) begin
      bus.ReadData = {mem[rdIdx + 10'd3], mem[rdIdx + 10'd2], mem[rdIdx + 10'd1], mem[rdIdx]};
    end
  end

  // Memory captures a write at the edge that ends the MemWrite cycle, little-endian.
  always @(posedge clk) begin
    if (bus.MemWrite && (({1'b0, bus.ADDR} + 33'd3) < 33'(MEM_BYTES))) begin
      for (int b = 0; b < 4; b++) begin
        mem[bus.ADDR[9:0] + 10'(b)] = bus.WriteData[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected stream words and memory writes as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) doneCnt++;
      if (bus.MemWrite) begin
        memWrCnt++;
        if (wrAddrQ.size() == 0) begin
          checkOutput("unexpected_memwrite", {31'h0, bus.MemWrite}, 32'h0);
        end else begin
          checkOutput("wr_addr", bus.ADDR, wrAddrQ[0]);
          checkOutput("wr_data", bus.WriteData, wrDataQ[0]);
          void'(wrAddrQ.pop_front());
          void'(wrDataQ.pop_front());
        end
      end
      if (bus.m_valid) begin
        if (rdQ.size() == 0) begin
          checkOutput("unexpected_m_valid", {31'h0, bus.m_valid}, 32'h0);
        end else begin
          checkOutput("m_data", bus.m_data, rdQ[0]);
          if (bus.m_ready) void'(rdQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic md, input logic [31:0] base, input logic [31:0] strd,
                               input logic [CNT_W-1:0] cnt);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.mode       = md;
    bus.base_addr  = base;
    bus.stride     = strd;
    bus.word_count = cnt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, output int n);
    n = maxCycles + 1;
    for (int k = 1; k <= maxCycles; k++) begin
      @(negedge clk);
      if (bus.done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic sendWord(input logic [31:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.s_ready) break;
    end
    checkOutput("s_ready_wait", {31'h0, bus.s_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
    checkOutput({tag, "_done"}, {31'h0, bus.done}, 32'h0);
    checkOutput({tag, "_err"}, {31'h0, bus.err}, 32'h0);
    checkOutput({tag, "_m_valid"}, {31'h0, bus.m_valid}, 32'h0);
    checkOutput({tag, "_memwrite"}, {31'h0, bus.MemWrite}, 32'h0);
    checkOutput({tag, "_s_ready"}, {31'h0, bus.s_ready}, 32'h0);
    checkOutput({tag, "_addr"}, bus.ADDR, 32'h0);
    checkOutput({tag, "_wdata"}, bus.WriteData, 32'h0);
    checkOutput({tag, "_m_data"}, bus.m_data, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int d0;
    int w0;
    logic [3:0] rdyPat;

    checks   = 0;
    errors   = 0;
    doneCnt  = 0;
    memWrCnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.mode       = MODE_RD;
    bus.base_addr  = 32'h0;
    bus.stride     = 32'h0;
    bus.word_count = '0;
    bus.m_ready    = 1'b1;
    bus.s_valid    = 1'b0;
    bus.s_data     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset");

    // Read 4 words from 0x10 with m_ready held high.
    $display("[TB] read burst");
    d0 = doneCnt;
    rdQ.push_back(32'h13121110);
    rdQ.push_back(32'h17161514);
    rdQ.push_back(32'h1B1A1918);
    rdQ.push_back(32'h1F1E1D1C);
    applyStimulus(MODE_RD, 32'h10, 32'd4, 16'd4);
    @(negedge clk);
    checkOutput("rd_busy", {31'h0, bus.busy}, 32'h1);
    checkOutput("rd_first_not_yet", {31'h0, bus.m_valid}, 32'h0);
    @(negedge clk);
    checkOutput("rd_first_valid", {31'h0, bus.m_valid}, 32'h1);
    waitDone(20, n);
    checkOutput("rd_done_latency", n, 32'd4);
    checkOutput("rd_err", {31'h0, bus.err}, 32'h0);
    @(negedge clk);
    checkOutput("rd_done_count", doneCnt - d0, 32'd1);
    checkOutput("rd_queue_empty", rdQ.size(), 32'd0);

    // Read 4 words from 0x40 with a stalling consumer.
    $display("[TB] read with back-pressure");
    d0 = doneCnt;
    rdyPat = 4'b1001;
    rdQ.push_back(32'h43424140);
    rdQ.push_back(32'h47464544);
    rdQ.push_back(32'h4B4A4948);
    rdQ.push_back(32'h4F4E4D4C);
    applyStimulus(MODE_RD, 32'h40, 32'd4, 16'd4);
    for (int c = 0; c < 40 && doneCnt == d0; c++) begin
      bus.m_ready = rdyPat[c % 4];
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_done_count", doneCnt - d0, 32'd1);
    checkOutput("stall_queue_empty", rdQ.size(), 32'd0);

    // Write 3 words at 0x20 with gaps in s_valid.
    $display("[TB] write burst");
    d0 = doneCnt;
    w0 = memWrCnt;
    wrAddrQ.push_back(32'h20); wrDataQ.push_back(32'hA1B2C3D4);
    wrAddrQ.push_back(32'h24); wrDataQ.push_back(32'h11223344);
    wrAddrQ.push_back(32'h28); wrDataQ.push_back(32'hDEADBEEF);
    applyStimulus(MODE_WR, 32'h20, 32'd4, 16'd3);
    @(posedge clk);
    #1;
    sendWord(32'hA1B2C3D4);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sendWord(32'h11223344);
    sendWord(32'hDEADBEEF);
    waitDone(10, n);
    checkOutput("wr_done_seen", {31'h0, bus.done}, 32'h1);
    checkOutput("wr_memwrite_count", memWrCnt - w0, 32'd3);
    checkOutput("wr_byte20", {24'h0, mem[32'h20]}, 32'hD4);
    checkOutput("wr_byte23", {24'h0, mem[32'h23]}, 32'hA1);
    checkOutput("wr_byte24", {24'h0, mem[32'h24]}, 32'h44);
    checkOutput("wr_byte2b", {24'h0, mem[32'h2B]}, 32'hDE);
    checkOutput("wr_byte2c", {24'h0, mem[32'h2C]}, 32'h2C);
    @(negedge clk);
    checkOutput("wr_done_count", doneCnt - d0, 32'd1);

    // Range error: 1012 is the last legal word, 1016 is rejected.
    $display("[TB] range error");
    d0 = doneCnt;
    rdQ.push_back(32'hF7F6F5F4);
    applyStimulus(MODE_RD, 32'd1012, 32'd4, 16'd3);
    waitDone(20, n);
    checkOutput("range_done_latency", n, 32'd3);
    checkOutput("range_err_set", {31'h0, bus.err}, 32'h1);
    checkOutput("range_queue_empty", rdQ.size(), 32'd0);

    // Zero-length transfer also clears the sticky error.
    $display("[TB] zero-length transfer");
    applyStimulus(MODE_RD, 32'h10, 32'd4, 16'd0);
    @(negedge clk);
    checkOutput("zero_err_cleared", {31'h0, bus.err}, 32'h0);
    checkOutput("zero_busy", {31'h0, bus.busy}, 32'h1);
    checkOutput("zero_no_done_yet", {31'h0, bus.done}, 32'h0);
    waitDone(10, n);
    checkOutput("zero_done_latency", n, 32'd1);
    @(negedge clk);
    checkOutput("range_zero_done_count", doneCnt - d0, 32'd2);

    // A start pulse while running must be ignored.
    $display("[TB] start during run");
    d0 = doneCnt;
    w0 = memWrCnt;
    rdQ.push_back(32'h13121110);
    rdQ.push_back(32'h17161514);
    applyStimulus(MODE_RD, 32'h10, 32'd4, 16'd2);
    bus.start      = 1'b1;
    bus.mode       = MODE_WR;
    bus.base_addr  = 32'h100;
    bus.word_count = 16'd5;
    bus.s_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(10, n);
    checkOutput("ignore_done_latency", n, 32'd3);
    repeat (4) @(negedge clk);
    bus.s_valid = 1'b0;
    checkOutput("ignore_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("ignore_done_count", doneCnt - d0, 32'd1);
    checkOutput("ignore_no_write", memWrCnt - w0, 32'd0);
    checkOutput("ignore_queue_empty", rdQ.size(), 32'd0);

    // Reset in the middle of a 5-word write after 2 words.
    $display("[TB] reset mid-write");
    w0 = memWrCnt;
    wrAddrQ.push_back(32'h80); wrDataQ.push_back(32'h01020304);
    wrAddrQ.push_back(32'h84); wrDataQ.push_back(32'h05060708);
    applyStimulus(MODE_WR, 32'h80, 32'd4, 16'd5);
    sendWord(32'h01020304);
    sendWord(32'h05060708);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("midrst");
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hCAFEF00D;
    repeat (4) @(negedge clk);
    checkOutput("midrst_s_ready", {31'h0, bus.s_ready}, 32'h0);
    bus.s_valid = 1'b0;
    checkOutput("midrst_write_count", memWrCnt - w0, 32'd2);
    checkOutput("midrst_byte80", {24'h0, mem[32'h80]}, 32'h04);
    checkOutput("midrst_byte87", {24'h0, mem[32'h87]}, 32'h05);
    checkOutput("midrst_byte88", {24'h0, mem[32'h88]}, 32'h88);
    checkOutput("midrst_wq_empty", wrAddrQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
